imem_arbiter: RTL and testbench

//  Shares the single synchronous-read instruction memory (ins_memory) between
//  two requesters: port 0 = core fetch, port 1 = debug/trace readout.

---
 rtl/imem_arbiter.sv | 89 ++++++++
 tb/tb_imem_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-port read arbiter in front of the synchronous instruction memory.
// Port 0 is core fetch and port 1 is debug readout; each returned word is routed back by tag.
module imem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef struct packed {
    logic valid;
    logic port_id;
  } tag_t;

  tag_t              tag_q [RD_LAT];
  logic              last_winner;
  logic [ADDR_W-1:0] addr_hold;
  logic              pick1;
  tag_t              tag_out;

  always_comb begin
    pick1 = 1'b0;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (req0 && req1)
      pick1 = (PRIO_FIXED == 0) && !last_winner;
    else
      pick1 = req1;
    if (!reset) begin
      gnt0 = req0 && !pick1;
      gnt1 = req1 && pick1;
    end
  end

  // Idle cycles replay the last address so the memory input stays quiet.
  always_comb begin
    mem_addr = addr_hold;
    if (gnt1)
      mem_addr = addr1;
    else if (gnt0)
      mem_addr = addr0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner <= 1'b1;
      addr_hold   <= '0;
      for (int i = 0; i < RD_LAT; i++)
        tag_q[i] <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        last_winner <= gnt1;
        addr_hold   <= mem_addr;
      end
      tag_q[0] <= '{valid: gnt0 || gnt1, port_id: gnt1};
      for (int i = 1; i < RD_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++)
      busy = busy || tag_q[i].valid;
  end

  assign tag_out = tag_q[RD_LAT-1];
  assign rvalid0 = tag_out.valid && !tag_out.port_id;
  assign rvalid1 = tag_out.valid && tag_out.port_id;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: three variants (RR lat1, fixed lat1, RR lat2)
// share one stimulus stream and are checked against a cycle-slot scoreboard.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  addr0, addr1;
  logic [2:0]  g0, g1, rv0, rv1, bsy;
  logic [7:0]  maddr [3];
  logic [31:0] rd0 [3];
  logic [31:0] rd1 [3];
  logic [31:0] mrd [3];
  logic [31:0] mp [3][4];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int  lat_of [3] = '{1, 1, 2};
  bit  fix_of [3] = '{1'b0, 1'b1, 1'b0};
  bit  sv [3][8];
  bit  sp [3][8];
  logic [7:0] sa [3][8];
  bit  lw [3];
  logic [7:0] hold [3];

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .PRIO_FIXED(0)) u0 (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(g0[0]), .rvalid0(rv0[0]), .rdata0(rd0[0]),
    .req1(req1), .addr1(addr1), .gnt1(g1[0]), .rvalid1(rv1[0]), .rdata1(rd1[0]),
    .mem_addr(maddr[0]), .mem_rdata(mrd[0]), .busy(bsy[0]));

  imem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .PRIO_FIXED(1)) u1 (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(g0[1]), .rvalid0(rv0[1]), .rdata0(rd0[1]),
    .req1(req1), .addr1(addr1), .gnt1(g1[1]), .rvalid1(rv1[1]), .rdata1(rd1[1]),
    .mem_addr(maddr[1]), .mem_rdata(mrd[1]), .busy(bsy[1]));

  imem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(2), .PRIO_FIXED(0)) u2 (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .gnt0(g0[2]), .rvalid0(rv0[2]), .rdata0(rd0[2]),
    .req1(req1), .addr1(addr1), .gnt1(g1[2]), .rvalid1(rv1[2]), .rdata1(rd1[2]),
    .mem_addr(maddr[2]), .mem_rdata(mrd[2]), .busy(bsy[2]));

  // Memory model: mem[a] = A000_0000 + a, keeps returning data through reset.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mp[k][0] <= 32'hA000_0000 + {24'h0, maddr[k]};
      for (int s = 1; s < 4; s++)
        mp[k][s] <= mp[k][s-1];
    end
  end

  assign mrd[0] = mp[0][0];
  assign mrd[1] = mp[1][0];
  assign mrd[2] = mp[2][1];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    lw[k]   = 1'b1;
    hold[k] = 8'h00;
    for (int s = 0; s < 8; s++) begin
      sv[k][s] = 1'b0;
      sp[k][s] = 1'b0;
      sa[k][s] = 8'h00;
    end
  endtask

  task automatic step(input logic rst_i, input logic r0_i, input logic r1_i,
                      input logic [7:0] a0_i, input logic [7:0] a1_i);
    int  slot;
    int  w;
    bit  be;
    bit  ev;
    bit  ep;
    logic [7:0] ea;
    logic [7:0] eaddr;
    reset = rst_i;
    req0  = r0_i;
    req1  = r1_i;
    addr0 = a0_i;
    addr1 = a1_i;
    #4;
    for (int k = 0; k < 3; k++) begin
      if (rst_i) begin
        chk($sformatf("u%0d.rst.gnt0", k), {63'b0, g0[k]}, 64'd0);
        chk($sformatf("u%0d.rst.gnt1", k), {63'b0, g1[k]}, 64'd0);
        chk($sformatf("u%0d.rst.rv0", k), {63'b0, rv0[k]}, 64'd0);
        chk($sformatf("u%0d.rst.rv1", k), {63'b0, rv1[k]}, 64'd0);
        chk($sformatf("u%0d.rst.busy", k), {63'b0, bsy[k]}, 64'd0);
        chk($sformatf("u%0d.rst.maddr", k), {56'b0, maddr[k]}, 64'd0);
        model_reset(k);
        continue;
      end
      be = 1'b0;
      for (int d = 0; d < lat_of[k]; d++)
        be = be | sv[k][(cyc + d) % 8];
      chk($sformatf("u%0d.busy", k), {63'b0, bsy[k]}, {63'b0, be});
      slot = cyc % 8;
      ev = sv[k][slot];
      ep = sp[k][slot];
      ea = sa[k][slot];
      sv[k][slot] = 1'b0;
      chk($sformatf("u%0d.rvalid0", k), {63'b0, rv0[k]}, {63'b0, ev && !ep});
      chk($sformatf("u%0d.rvalid1", k), {63'b0, rv1[k]}, {63'b0, ev && ep});
      if (ev && !ep)
        chk($sformatf("u%0d.rdata0", k), {32'b0, rd0[k]},
            {32'b0, 32'hA000_0000 + {24'h0, ea}});
      if (ev && ep)
        chk($sformatf("u%0d.rdata1", k), {32'b0, rd1[k]},
            {32'b0, 32'hA000_0000 + {24'h0, ea}});
      // Winner from the arbitration rule; -1 means no grant this cycle.
      if (r0_i && r1_i)
        w = fix_of[k] ? 0 : (lw[k] ? 0 : 1);
      else if (r0_i)
        w = 0;
      else if (r1_i)
        w = 1;
      else
        w = -1;
      eaddr = (w == 0) ? a0_i : (w == 1) ? a1_i : hold[k];
      chk($sformatf("u%0d.gnt0", k), {63'b0, g0[k]}, {63'b0, w == 0});
      chk($sformatf("u%0d.gnt1", k), {63'b0, g1[k]}, {63'b0, w == 1});
      chk($sformatf("u%0d.maddr", k), {56'b0, maddr[k]}, {56'b0, eaddr});
      if (w >= 0) begin
        lw[k]   = (w == 1);
        hold[k] = eaddr;
        slot = (cyc + lat_of[k]) % 8;
        sv[k][slot] = 1'b1;
        sp[k][slot] = (w == 1);
        sa[k][slot] = eaddr;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    addr0 = 8'h00;
    addr1 = 8'h00;
    for (int k = 0; k < 3; k++)
      model_reset(k);
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    // Single port-0 read.
    step(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Both held: alternation (RR) versus port 0 always (fixed).
    repeat (6) step(1'b0, 1'b1, 1'b1, 8'h0A, 8'h14);
    step(1'b0, 1'b0, 1'b1, 8'h0A, 8'h14);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Port 1 alone, then port 0 joins.
    repeat (3) step(1'b0, 1'b0, 1'b1, 8'h00, 8'h33);
    repeat (4) step(1'b0, 1'b1, 1'b1, 8'h44, 8'h33);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Back-to-back port-0 reads, then reset while they are in flight.
    step(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h02, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (5) step(1'b0, 1'b1, 1'b0, 8'h07, 8'h00);
    repeat (6) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom));
    repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
